// File: rtl/z80fi_insn_packer_if.sv
// Event and retirement bundle for z80fi_insn_packer.
// master = CPU core side (drives the events), slave = the packer.
interface z80fi_insn_packer_if;
    logic        insn_start;
    logic [15:0] pc_start;
    logic        fetch_valid;
    logic [7:0]  fetch_byte;
    logic        rd_valid;
    logic [3:0]  rd_num;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic [3:0]  wr_num;
    logic [15:0] wr_data;
    logic        i_wr_valid;
    logic [7:0]  i_wr_data;
    logic        insn_done;
    logic [15:0] pc_next;

    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_pc_rdata;
    logic [15:0] z80fi_pc_wdata;
    logic [3:0]  z80fi_reg1_rnum;
    logic [15:0] z80fi_reg1_rdata;
    logic [3:0]  z80fi_reg2_rnum;
    logic [15:0] z80fi_reg2_rdata;
    logic        z80fi_reg_wr;
    logic [3:0]  z80fi_reg_wnum;
    logic [15:0] z80fi_reg_wdata;
    logic        z80fi_i_wr;
    logic [7:0]  z80fi_i_wdata;
    logic        z80fi_err;

    modport master (
        output insn_start, pc_start, fetch_valid, fetch_byte,
               rd_valid, rd_num, rd_data, wr_valid, wr_num, wr_data,
               i_wr_valid, i_wr_data, insn_done, pc_next,
        input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata,
               z80fi_pc_wdata, z80fi_reg1_rnum, z80fi_reg1_rdata,
               z80fi_reg2_rnum, z80fi_reg2_rdata, z80fi_reg_wr,
               z80fi_reg_wnum, z80fi_reg_wdata, z80fi_i_wr, z80fi_i_wdata,
               z80fi_err
    );

    modport slave (
        input  insn_start, pc_start, fetch_valid, fetch_byte,
               rd_valid, rd_num, rd_data, wr_valid, wr_num, wr_data,
               i_wr_valid, i_wr_data, insn_done, pc_next,
        output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata,
               z80fi_pc_wdata, z80fi_reg1_rnum, z80fi_reg1_rdata,
               z80fi_reg2_rnum, z80fi_reg2_rdata, z80fi_reg_wr,
               z80fi_reg_wnum, z80fi_reg_wdata, z80fi_i_wr, z80fi_i_wdata,
               z80fi_err
    );
endinterface

// File: rtl/z80fi_insn_packer.sv
// Z80 formal-interface instruction packer: accumulates per-instruction
// fetch/register events and emits one retirement record per instruction.
// Optional macro Z80FI_PACKER_ERRCHK_EN enables the sticky z80fi_err flag
// (byte/read overflow, stray insn_done, restart without retirement);
// without it z80fi_err is tied to 0 and drop behaviour is identical.
module z80fi_insn_packer (
    input  logic                   clk,
    input  logic                   reset,
    z80fi_insn_packer_if.slave     bus
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    typedef struct packed {
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] pc;
        logic [3:0]  r1n;
        logic [15:0] r1d;
        logic [3:0]  r2n;
        logic [15:0] r2d;
        logic        wr;
        logic [3:0]  wn;
        logic [15:0] wd;
        logic        iw;
        logic [7:0]  id;
    } acc_t;

    logic [0:0]  st_q;
    acc_t        acc_q, base, m, n, out_q;
    logic [1:0]  nrd_q, base_nrd, m_nrd;
    logic [15:0] pc_wdata_q;
    logic        valid_q;
    logic        retire, fresh, act, fetch_eff, rd_eff, restart_on_done;

    // An instruction retires only from COLLECT; a same-cycle insn_start keeps
    // the fetch for the new instruction while other events go to the old one.
    assign retire          = (st_q == COLLECT) && bus.insn_done;
    assign restart_on_done = retire && bus.insn_start;
    assign fresh           = bus.insn_start && !retire;
    assign act             = (st_q == COLLECT) || bus.insn_start;
    assign fetch_eff       = act && bus.fetch_valid && !restart_on_done;
    assign rd_eff          = act && bus.rd_valid;

    // Merge this cycle's events into the (possibly fresh) accumulator.
    always_comb begin
        base     = acc_q;
        base_nrd = nrd_q;
        if (fresh) begin
            base     = '0;
            base.pc  = bus.pc_start;
            base_nrd = 2'd0;
        end
        m     = base;
        m_nrd = base_nrd;
        if (fetch_eff && base.len != 3'd4) begin
            m.insn[{base.len[1:0], 3'b000} +: 8] = bus.fetch_byte;
            m.len = base.len + 3'd1;
        end
        if (rd_eff) begin
            if (base_nrd == 2'd0) begin
                m.r1n = bus.rd_num;
                m.r1d = bus.rd_data;
                m_nrd = 2'd1;
            end else if (base_nrd == 2'd1) begin
                m.r2n = bus.rd_num;
                m.r2d = bus.rd_data;
                m_nrd = 2'd2;
            end
        end
        if (act && bus.wr_valid) begin
            m.wr = 1'b1;
            m.wn = bus.wr_num;
            m.wd = bus.wr_data;
        end
        if (act && bus.i_wr_valid) begin
            m.iw = 1'b1;
            m.id = bus.i_wr_data;
        end
        n = m;
        if (restart_on_done) begin
            n    = '0;
            n.pc = bus.pc_start;
            if (bus.fetch_valid) begin
                n.insn[7:0] = bus.fetch_byte;
                n.len       = 3'd1;
            end
        end
    end

    // State, accumulator and registered retirement record.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= IDLE;
            acc_q      <= '0;
            nrd_q      <= 2'd0;
            out_q      <= '0;
            pc_wdata_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= retire;
            acc_q   <= n;
            nrd_q   <= restart_on_done ? 2'd0 : m_nrd;
            if (retire) begin
                out_q      <= m;
                pc_wdata_q <= bus.pc_next;
            end
            if (bus.insn_start)
                st_q <= COLLECT;
            else if (retire)
                st_q <= IDLE;
        end
    end

`ifdef Z80FI_PACKER_ERRCHK_EN
    logic err_q, err_evt;
    assign err_evt = (fetch_eff && base.len == 3'd4)
                  || (rd_eff && base_nrd == 2'd2)
                  || (bus.insn_done && st_q == IDLE)
                  || (bus.insn_start && st_q == COLLECT && !bus.insn_done);

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (err_evt)
            err_q <= 1'b1;
    end
    assign bus.z80fi_err = err_q;
`else
    assign bus.z80fi_err = 1'b0;
`endif

    assign bus.z80fi_valid      = valid_q;
    assign bus.z80fi_insn       = out_q.insn;
    assign bus.z80fi_insn_len   = out_q.len;
    assign bus.z80fi_pc_rdata   = out_q.pc;
    assign bus.z80fi_pc_wdata   = pc_wdata_q;
    assign bus.z80fi_reg1_rnum  = out_q.r1n;
    assign bus.z80fi_reg1_rdata = out_q.r1d;
    assign bus.z80fi_reg2_rnum  = out_q.r2n;
    assign bus.z80fi_reg2_rdata = out_q.r2d;
    assign bus.z80fi_reg_wr     = out_q.wr;
    assign bus.z80fi_reg_wnum   = out_q.wn;
    assign bus.z80fi_reg_wdata  = out_q.wd;
    assign bus.z80fi_i_wr       = out_q.iw;
    assign bus.z80fi_i_wdata    = out_q.id;
endmodule

// File: tb/tb_z80fi_insn_packer.sv
// Self-checking bench for z80fi_insn_packer: table of whole instructions
// plus hand-written multi-cycle sequences. Honors Z80FI_PACKER_ERRCHK_EN.
module tb_z80fi_insn_packer;
`ifdef Z80FI_PACKER_ERRCHK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif
    // Bench-local register numbers; the packer passes them through untouched.
    localparam logic [3:0] RA = 4'd1, RB = 4'd2, RC = 4'd3, RIX = 4'd10;

    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] pcr, pcw;
        logic [3:0]  r1n;
        logic [15:0] r1d;
        logic [3:0]  r2n;
        logic [15:0] r2d;
        logic        rw;
        logic [3:0]  wn;
        logic [15:0] wd;
        logic        iw;
        logic [7:0]  id;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [15:0]      pc;
        logic [2:0]       nb, nr;
        logic [4:0][7:0]  b;
        logic [2:0][3:0]  rn;
        logic [2:0][15:0] rd;
        logic             wv;
        logic [3:0]       wn;
        logic [15:0]      wd;
        logic             iv;
        logic [7:0]       id;
        logic [15:0]      pcn;
        exp_t             e;
    } vec_t;

    typedef struct packed {
        logic        rst, start;
        logic [15:0] pc;
        logic        fv;
        logic [7:0]  fb;
        logic        rv;
        logic [3:0]  rn;
        logic [15:0] rd;
        logic        wv;
        logic [3:0]  wn;
        logic [15:0] wd;
        logic        iv;
        logic [7:0]  id;
        logic        done;
        logic [15:0] pcn;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   ncmp = 0, nerr = 0;

    z80fi_insn_packer_if bus ();
    z80fi_insn_packer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs; returns at the following falling edge.
    task automatic step(input ev_t e);
        reset           = e.rst;
        bus.insn_start  = e.start;  bus.pc_start   = e.pc;
        bus.fetch_valid = e.fv;     bus.fetch_byte = e.fb;
        bus.rd_valid    = e.rv;     bus.rd_num     = e.rn;  bus.rd_data = e.rd;
        bus.wr_valid    = e.wv;     bus.wr_num     = e.wn;  bus.wr_data = e.wd;
        bus.i_wr_valid  = e.iv;     bus.i_wr_data  = e.id;
        bus.insn_done   = e.done;   bus.pc_next    = e.pcn;
        @(negedge clk);
    endtask

    task automatic chk_exp(input string t, input exp_t x);
        chk({t, ".valid"}, 32'(bus.z80fi_valid),      32'(x.valid));
        chk({t, ".insn"},  bus.z80fi_insn,            x.insn);
        chk({t, ".len"},   32'(bus.z80fi_insn_len),   32'(x.len));
        chk({t, ".pcr"},   32'(bus.z80fi_pc_rdata),   32'(x.pcr));
        chk({t, ".pcw"},   32'(bus.z80fi_pc_wdata),   32'(x.pcw));
        chk({t, ".r1n"},   32'(bus.z80fi_reg1_rnum),  32'(x.r1n));
        chk({t, ".r1d"},   32'(bus.z80fi_reg1_rdata), 32'(x.r1d));
        chk({t, ".r2n"},   32'(bus.z80fi_reg2_rnum),  32'(x.r2n));
        chk({t, ".r2d"},   32'(bus.z80fi_reg2_rdata), 32'(x.r2d));
        chk({t, ".rw"},    32'(bus.z80fi_reg_wr),     32'(x.rw));
        chk({t, ".wn"},    32'(bus.z80fi_reg_wnum),   32'(x.wn));
        chk({t, ".wd"},    32'(bus.z80fi_reg_wdata),  32'(x.wd));
        chk({t, ".iw"},    32'(bus.z80fi_i_wr),       32'(x.iw));
        chk({t, ".id"},    32'(bus.z80fi_i_wdata),    32'(x.id));
        chk({t, ".err"},   32'(bus.z80fi_err),        32'(x.err));
    endtask

    task automatic do_reset();
        ev_t e = '0;
        e.rst = 1'b1;
        step(e);
    endtask

    // Drive one instruction from the table, retire it, check the record.
    task automatic run_vec(input int i, input vec_t v);
        ev_t e;
        int  ncyc = (v.nb > v.nr) ? int'(v.nb) : int'(v.nr);
        for (int k = 0; k < ncyc; k++) begin
            e = '0;
            e.start = (k == 0);
            e.pc    = v.pc;
            if (k < int'(v.nb)) begin e.fv = 1'b1; e.fb = v.b[k]; end
            if (k < int'(v.nr)) begin e.rv = 1'b1; e.rn = v.rn[k]; e.rd = v.rd[k]; end
            step(e);
        end
        e = '0;
        e.done = 1'b1; e.pcn = v.pcn;
        e.wv = v.wv; e.wn = v.wn; e.wd = v.wd;
        e.iv = v.iv; e.id = v.id;
        step(e);
        chk_exp($sformatf("vec%0d", i), v.e);
        step('0);
        chk($sformatf("vec%0d.pulse_end", i), 32'(bus.z80fi_valid), 32'd0);
        chk($sformatf("vec%0d.hold_insn", i), bus.z80fi_insn, v.e.insn);
    endtask

    vec_t vecs[6];
    exp_t x;
    ev_t  e;

    initial begin
        // LD I,A
        vecs[0] = '0; vecs[0].pc = 16'h1234; vecs[0].nb = 3'd2; vecs[0].b[0] = 8'hED; vecs[0].b[1] = 8'h47;
        vecs[0].nr = 3'd1; vecs[0].rn[0] = RA; vecs[0].rd[0] = 16'h0055; vecs[0].iv = 1'b1; vecs[0].id = 8'h55;
        vecs[0].pcn = 16'h1236;
        vecs[0].e = '0; vecs[0].e.valid = 1'b1; vecs[0].e.insn = 32'h000047ED; vecs[0].e.len = 3'd2;
        vecs[0].e.pcr = 16'h1234; vecs[0].e.pcw = 16'h1236; vecs[0].e.r1n = RA; vecs[0].e.r1d = 16'h0055;
        vecs[0].e.iw = 1'b1; vecs[0].e.id = 8'h55;
        // five fetches: fifth dropped
        vecs[1] = '0; vecs[1].pc = 16'h0100; vecs[1].nb = 3'd5;
        vecs[1].b = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11}; vecs[1].pcn = 16'h0105;
        vecs[1].e = '0; vecs[1].e.valid = 1'b1; vecs[1].e.insn = 32'h44332211; vecs[1].e.len = 3'd4;
        vecs[1].e.pcr = 16'h0100; vecs[1].e.pcw = 16'h0105; vecs[1].e.err = ERR_ON;
        // three reads: third dropped; write lands on the done cycle
        vecs[2] = '0; vecs[2].pc = 16'h2000; vecs[2].nb = 3'd1; vecs[2].b[0] = 8'h80;
        vecs[2].nr = 3'd3; vecs[2].rn = {RC, RB, RA}; vecs[2].rd = {16'h3333, 16'h2222, 16'h1111};
        vecs[2].wv = 1'b1; vecs[2].wn = RB; vecs[2].wd = 16'hABCD; vecs[2].pcn = 16'h2001;
        vecs[2].e = '0; vecs[2].e.valid = 1'b1; vecs[2].e.insn = 32'h00000080; vecs[2].e.len = 3'd1;
        vecs[2].e.pcr = 16'h2000; vecs[2].e.pcw = 16'h2001; vecs[2].e.r1n = RA; vecs[2].e.r1d = 16'h1111;
        vecs[2].e.r2n = RB; vecs[2].e.r2d = 16'h2222; vecs[2].e.rw = 1'b1; vecs[2].e.wn = RB;
        vecs[2].e.wd = 16'hABCD; vecs[2].e.err = ERR_ON;
        // LD IX,1234h: exactly four bytes, no error
        vecs[3] = '0; vecs[3].pc = 16'h3000; vecs[3].nb = 3'd4;
        vecs[3].b = {8'h00, 8'h12, 8'h34, 8'h21, 8'hDD}; vecs[3].wv = 1'b1; vecs[3].wn = RIX;
        vecs[3].wd = 16'h1234; vecs[3].pcn = 16'h3004;
        vecs[3].e = '0; vecs[3].e.valid = 1'b1; vecs[3].e.insn = 32'h123421DD; vecs[3].e.len = 3'd4;
        vecs[3].e.pcr = 16'h3000; vecs[3].e.pcw = 16'h3004; vecs[3].e.rw = 1'b1; vecs[3].e.wn = RIX;
        vecs[3].e.wd = 16'h1234;
        // NOP at top of memory, PC wraps
        vecs[4] = '0; vecs[4].pc = 16'hFFFF; vecs[4].nb = 3'd1; vecs[4].b[0] = 8'h00; vecs[4].pcn = 16'h0000;
        vecs[4].e = '0; vecs[4].e.valid = 1'b1; vecs[4].e.len = 3'd1; vecs[4].e.pcr = 16'hFFFF;
        // three bytes, two reads
        vecs[5] = '0; vecs[5].pc = 16'h4000; vecs[5].nb = 3'd3; vecs[5].b = {8'h00, 8'h00, 8'h80, 8'h00, 8'h32};
        vecs[5].nr = 3'd2; vecs[5].rn = {4'd0, RB, RA}; vecs[5].rd = {16'h0000, 16'h0013, 16'h0042};
        vecs[5].pcn = 16'h4003;
        vecs[5].e = '0; vecs[5].e.valid = 1'b1; vecs[5].e.insn = 32'h00800032; vecs[5].e.len = 3'd3;
        vecs[5].e.pcr = 16'h4000; vecs[5].e.pcw = 16'h4003; vecs[5].e.r1n = RA; vecs[5].e.r1d = 16'h0042;
        vecs[5].e.r2n = RB; vecs[5].e.r2d = 16'h0013;

        // reset state
        do_reset();
        chk_exp("reset", '0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_vec(i, vecs[i]);
        end

        // back-to-back: done + start in the same cycle
        do_reset();
        e = '0; e.start = 1'b1; e.pc = 16'h0300; e.fv = 1'b1; e.fb = 8'h3A; e.rv = 1'b1; e.rn = RA; e.rd = 16'h00AA;
        step(e);
        e = '0; e.fv = 1'b1; e.fb = 8'h34; step(e);
        e = '0; e.done = 1'b1; e.pcn = 16'h0302; e.start = 1'b1; e.pc = 16'h0302; e.fv = 1'b1; e.fb = 8'h00;
        e.rv = 1'b1; e.rn = RB; e.rd = 16'h00BB;
        step(e);
        x = '0; x.valid = 1'b1; x.insn = 32'h0000343A; x.len = 3'd2; x.pcr = 16'h0300; x.pcw = 16'h0302;
        x.r1n = RA; x.r1d = 16'h00AA; x.r2n = RB; x.r2d = 16'h00BB;
        chk_exp("b2b_first", x);
        e = '0; e.done = 1'b1; e.pcn = 16'h0303; step(e);
        x = '0; x.valid = 1'b1; x.insn = 32'h00000000; x.len = 3'd1; x.pcr = 16'h0302; x.pcw = 16'h0303;
        chk_exp("b2b_second", x);

        // reset mid-instruction beats a simultaneous insn_done
        do_reset();
        run_vec(6, vecs[0]);
        e = '0; e.start = 1'b1; e.pc = 16'h0400; e.fv = 1'b1; e.fb = 8'h11; step(e);
        e = '0; e.fv = 1'b1; e.fb = 8'h22; step(e);
        e = '0; e.rst = 1'b1; e.done = 1'b1; e.pcn = 16'h0402; step(e);
        chk_exp("rst_mid", '0);
        step('0);
        chk("rst_mid.no_pulse", 32'(bus.z80fi_valid), 32'd0);

        // insn_done while idle
        do_reset();
        e = '0; e.done = 1'b1; e.pcn = 16'h0777; step(e);
        chk("idle_done.valid", 32'(bus.z80fi_valid), 32'd0);
        chk("idle_done.err", 32'(bus.z80fi_err), 32'(ERR_ON));
        step('0);
        chk("idle_done.err_sticky", 32'(bus.z80fi_err), 32'(ERR_ON));
        chk("idle_done.insn", bus.z80fi_insn, 32'd0);

        // idle events ignored; last register / I write wins
        do_reset();
        e = '0; e.fv = 1'b1; e.fb = 8'hFF; e.rv = 1'b1; e.rn = RA; e.rd = 16'hDEAD;
        e.wv = 1'b1; e.wn = RA; e.wd = 16'hBEEF; e.iv = 1'b1; e.id = 8'h77; step(e);
        e = '0; e.start = 1'b1; e.pc = 16'h0500; e.fv = 1'b1; e.fb = 8'h01;
        e.wv = 1'b1; e.wn = RB; e.wd = 16'h1111; e.iv = 1'b1; e.id = 8'h11; step(e);
        e = '0; e.fv = 1'b1; e.fb = 8'h02; e.wv = 1'b1; e.wn = RC; e.wd = 16'h2222; e.iv = 1'b1; e.id = 8'h22;
        step(e);
        e = '0; e.done = 1'b1; e.pcn = 16'h0502; step(e);
        x = '0; x.valid = 1'b1; x.insn = 32'h00000201; x.len = 3'd2; x.pcr = 16'h0500; x.pcw = 16'h0502;
        x.rw = 1'b1; x.wn = RC; x.wd = 16'h2222; x.iw = 1'b1; x.id = 8'h22;
        chk_exp("last_wr", x);

        // restart without retirement discards the partial instruction
        do_reset();
        e = '0; e.start = 1'b1; e.pc = 16'h0580; e.fv = 1'b1; e.fb = 8'hAA; e.rv = 1'b1; e.rn = RA; e.rd = 16'h0001;
        step(e);
        e = '0; e.start = 1'b1; e.pc = 16'h0600; e.fv = 1'b1; e.fb = 8'hBB; step(e);
        chk("restart.no_pulse", 32'(bus.z80fi_valid), 32'd0);
        e = '0; e.done = 1'b1; e.pcn = 16'h0601; step(e);
        x = '0; x.valid = 1'b1; x.insn = 32'h000000BB; x.len = 3'd1; x.pcr = 16'h0600; x.pcw = 16'h0601;
        x.err = ERR_ON;
        chk_exp("restart", x);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, want finish");
        $fatal(1);
    end
endmodule

// File: doc/z80fi_insn_packer.md
Z80FI_INSN_PACKER -- requirements
Module: z80fi_insn_packer

Interface
REQ-001 SHALL: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: insn_start  in  1  first-opcode-fetch strobe of a new instruction.
REQ-004 SHALL: pc_start  in  16  PC of instruction, sampled when insn_start=1.
REQ-005 SHALL: fetch_valid / fetch_byte  in  1 / 8  instruction byte (opcode or operand) fetched this cycle.
REQ-006 SHALL: rd_valid / rd_num / rd_data  in  1 / 4 / 16  register read event (REG_* encoding).
REQ-007 SHALL: wr_valid / wr_num / wr_data  in  1 / 4 / 16  register write event.
REQ-008 SHALL: i_wr_valid / i_wr_data  in  1 / 8  I-register write event.
REQ-009 SHALL: insn_done / pc_next  in  1 / 16  retirement strobe and next PC.
REQ-010 SHALL: z80fi_valid  out  1  one-cycle retirement pulse.
REQ-011 SHALL: z80fi_insn / z80fi_insn_len  out  32 / 3  packed bytes, byte count.
REQ-012 SHALL: z80fi_pc_rdata / z80fi_pc_wdata  out  16 / 16.
REQ-013 SHALL: z80fi_reg1_rnum, z80fi_reg1_rdata, z80fi_reg2_rnum, z80fi_reg2_rdata  out  4/16/4/16.
REQ-014 SHALL: z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata  out  1/4/16.
REQ-015 SHALL: z80fi_i_wr / z80fi_i_wdata  out  1 / 8.
REQ-016 SHALL: z80fi_err  out  1  sticky protocol-error flag.

Function
REQ-017 SHALL: FSM states IDLE, COLLECT; IDLE->COLLECT on insn_start; COLLECT->IDLE on insn_done without insn_start; COLLECT->COLLECT on insn_done with insn_start.
REQ-018 SHALL: k-th fetched byte (k=0..3) stored at insn[8k+7:8k]; unused bytes zero; fetch_valid with insn_start counts as byte 0.
REQ-019 SHALL: len saturate at 4; fifth and later bytes dropped, flag error.
REQ-020 SHALL: first read -> reg1, second -> reg2, third+ dropped with error; unread slots report rnum 0, rdata 0.
REQ-021 SHALL: last register write and last I write in instruction win; z80fi_reg_wr / z80fi_i_wr =1 only if such write occurred.
REQ-022 SHALL: events on insn_done cycle belong to retiring instruction; insn_start same cycle opens fresh accumulator (byte 0 = that cycle's fetch).
REQ-023 SHALL: insn_done in cycle N -> z80fi_valid=1 in N+1 only, all data outputs updated in N+1 and held until next retirement.
REQ-024 SHALL: insn_done in IDLE ignored (no pulse), flagged error; insn_start in COLLECT without insn_done discards partial instruction, flags error.
REQ-025 SHALL: events (fetch/rd/wr/i_wr) in IDLE without insn_start ignored.

Reset
REQ-026 SHALL: reset forces IDLE, clears accumulator, all outputs 0 next cycle, including z80fi_err.
REQ-027 SHALL: reset mid-COLLECT discards partial instruction; no z80fi_valid for it; reset wins over simultaneous insn_done.

Configuration
REQ-028 SHALL: macro Z80FI_PACKER_ERRCHK_EN defined -> error conditions of REQ-019/020/024 set z80fi_err, sticky until reset.
REQ-029 SHALL: macro undefined -> z80fi_err constant 0; dropping/ignoring behaviour unchanged.

Verification
REQ-030 SHALL: LD I,A: start pc_start=1234h, fetch EDh, 47h, rd A=0055h, i_wr 55h, done pc_next=1236h -> next cycle valid=1, insn=000047EDh, len=2, pc 1234h/1236h, reg1_rnum=REG_A, reg1_rdata=0055h, i_wr=1, i_wdata=55h, reg_wr=0.
REQ-031 SHALL: insn_done+insn_start same cycle (fetch 00h on that cycle) -> first instruction retires; next retirement insn[7:0]=00h, no carry-over of reads.
REQ-032 SHALL: five fetches 11h,22h,33h,44h,55h -> insn=44332211h, len=4, err=1 (macro on).
REQ-033 SHALL: reset asserted after two fetches, then insn_done -> no valid pulse, all outputs 0.
REQ-034 SHALL: three reads A,B,C -> reg1=A, reg2=B; err=1 with macro, 0 without.
REQ-035 SHALL: insn_done while IDLE -> no valid pulse; err=1 (macro on).
